// File: rtl/foosball_kick_arbiter_if.sv
//==============================================================================
// Module      : foosball_kick_arbiter_if
// Description : Kick request / ball-speed load bundle between the rods and the
//               kick arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface foosball_kick_arbiter_if #(
    parameter int NUM_RODS = 4
);
    logic                startOfFrame;
    logic [NUM_RODS-1:0] kickReq;
    logic [NUM_RODS-1:0] reqYUp;
    logic [NUM_RODS-1:0] grant;
    logic                loadSpeed;
    logic signed [10:0]  kickXSpeed;
    logic signed [10:0]  kickYSpeed;
    logic                kickActive;
    logic                busy;

    // Rod / frame side: raises requests, observes the granted kick
    modport master (
        output startOfFrame,
        output kickReq,
        output reqYUp,
        input  grant,
        input  loadSpeed,
        input  kickXSpeed,
        input  kickYSpeed,
        input  kickActive,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  startOfFrame,
        input  kickReq,
        input  reqYUp,
        output grant,
        output loadSpeed,
        output kickXSpeed,
        output kickYSpeed,
        output kickActive,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/foosball_kick_arbiter.sv
//==============================================================================
// Module      : foosball_kick_arbiter
// Description : Round-robin arbiter granting the shared ball-velocity load port
//               to one rod per kick, followed by a kick hold and a cooldown.
//               Optional macro KICK_PRIORITY_HUMAN_EN: human rods beat bot rods.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module foosball_kick_arbiter #(
    parameter int                  NUM_RODS        = 4,
    parameter logic [NUM_RODS-1:0] HUMAN_MASK      = 4'b0101,
    parameter int                  KICK_FRAMES     = 8,
    parameter int                  COOLDOWN_FRAMES = 15,
    parameter int                  KICK_X_SPEED    = 300,
    parameter int                  KICK_Y_SPEED    = 120
) (
    input  wire logic                    clk,
    input  wire logic                    resetN,
    foosball_kick_arbiter_if.slave       arb_if
);

    localparam int c_MAX_FRAMES = (KICK_FRAMES > COOLDOWN_FRAMES) ? KICK_FRAMES : COOLDOWN_FRAMES;
    localparam int c_CNT_W      = $clog2(c_MAX_FRAMES + 1);
    localparam int c_PTR_W      = $clog2(NUM_RODS);
    localparam int c_X_MAG      = (KICK_X_SPEED > 1023) ? 1023 : KICK_X_SPEED;
    localparam int c_Y_MAG      = (KICK_Y_SPEED > 1023) ? 1023 : KICK_Y_SPEED;

    localparam logic signed [10:0] c_X_POS = 11'(c_X_MAG);
    localparam logic signed [10:0] c_X_NEG = 11'(-c_X_MAG);
    localparam logic signed [10:0] c_Y_POS = 11'(c_Y_MAG);
    localparam logic signed [10:0] c_Y_NEG = 11'(-c_Y_MAG);

    localparam logic [c_CNT_W-1:0] c_KICK_END = c_CNT_W'(KICK_FRAMES);
    localparam logic [c_CNT_W-1:0] c_COOL_END = c_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_RODS - 1);
    localparam logic [c_PTR_W:0]   c_NUM      = (c_PTR_W + 1)'(NUM_RODS);
    localparam logic [NUM_RODS-1:0] c_ONE_HOT0 = NUM_RODS'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_KICK = 2'd1;
    localparam logic [1:0] c_ST_COOL = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [c_CNT_W-1:0]  frameCnt_q,  frameCnt_d;
    logic [c_PTR_W-1:0]  rrPtr_q,     rrPtr_d;
    logic [NUM_RODS-1:0] grant_q,     grant_d;
    logic                loadSpeed_q, loadSpeed_d;
    logic signed [10:0]  kickX_q,     kickX_d;
    logic signed [10:0]  kickY_q,     kickY_d;

    logic [NUM_RODS-1:0] w_cand;
    logic                w_found;
    logic [c_PTR_W-1:0]  w_sel;
    logic [c_PTR_W:0]    w_idx;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    // Rotating scan from rrPtr; the candidate set narrows to humans when enabled
    always_comb begin
        w_cand  = arb_if.kickReq;
`ifdef KICK_PRIORITY_HUMAN_EN
        if ((arb_if.kickReq & HUMAN_MASK) != '0) begin
            w_cand = arb_if.kickReq & HUMAN_MASK;
        end
`endif
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_RODS; k++) begin
            w_idx = (c_PTR_W + 1)'(rrPtr_q) + (c_PTR_W + 1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (!w_found && w_cand[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= c_ST_IDLE;
            frameCnt_q  <= '0;
            rrPtr_q     <= '0;
            grant_q     <= '0;
            loadSpeed_q <= 1'b0;
            kickX_q     <= '0;
            kickY_q     <= '0;
        end else begin
            state_q     <= state_d;
            frameCnt_q  <= frameCnt_d;
            rrPtr_q     <= rrPtr_d;
            grant_q     <= grant_d;
            loadSpeed_q <= loadSpeed_d;
            kickX_q     <= kickX_d;
            kickY_q     <= kickY_d;
        end
    end

    // Next-state logic; every transition waits for a frame boundary
    always_comb begin
        state_d     = state_q;
        frameCnt_d  = frameCnt_q;
        rrPtr_d     = rrPtr_q;
        grant_d     = grant_q;
        loadSpeed_d = 1'b0;
        kickX_d     = kickX_q;
        kickY_d     = kickY_q;
        w_cnt_inc   = frameCnt_q + c_CNT_ONE;

        case (state_q)
            c_ST_IDLE: begin
                if (arb_if.startOfFrame && w_found) begin
                    state_d     = c_ST_KICK;
                    frameCnt_d  = '0;
                    grant_d     = c_ONE_HOT0 << w_sel;
                    loadSpeed_d = 1'b1;
                    rrPtr_d     = (w_sel == c_PTR_LAST) ? '0 : w_sel + c_PTR_W'(1);
                    kickX_d     = HUMAN_MASK[w_sel]     ? c_X_POS : c_X_NEG;
                    kickY_d     = arb_if.reqYUp[w_sel]  ? c_Y_NEG : c_Y_POS;
                end
            end
            c_ST_KICK: begin
                if (arb_if.startOfFrame) begin
                    if (w_cnt_inc == c_KICK_END) begin
                        state_d    = (COOLDOWN_FRAMES == 0) ? c_ST_IDLE : c_ST_COOL;
                        frameCnt_d = '0;
                        grant_d    = '0;
                        kickX_d    = '0;
                        kickY_d    = '0;
                    end else begin
                        frameCnt_d = w_cnt_inc;
                    end
                end
            end
            c_ST_COOL: begin
                if (arb_if.startOfFrame) begin
                    if (w_cnt_inc == c_COOL_END) begin
                        state_d    = c_ST_IDLE;
                        frameCnt_d = '0;
                    end else begin
                        frameCnt_d = w_cnt_inc;
                    end
                end
            end
            default: begin
                state_d    = c_ST_IDLE;
                frameCnt_d = '0;
                grant_d    = '0;
                kickX_d    = '0;
                kickY_d    = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        arb_if.grant      = grant_q;
        arb_if.loadSpeed  = loadSpeed_q;
        arb_if.kickXSpeed = kickX_q;
        arb_if.kickYSpeed = kickY_q;
        arb_if.kickActive = (state_q == c_ST_KICK);
        arb_if.busy       = (state_q != c_ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_foosball_kick_arbiter.sv
//==============================================================================
// Module      : tb_foosball_kick_arbiter
// Description : Directed self-checking bench for foosball_kick_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_foosball_kick_arbiter;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    foosball_kick_arbiter_if #(.NUM_RODS(4)) if1 ();
    foosball_kick_arbiter_if #(.NUM_RODS(4)) if2 ();

    foosball_kick_arbiter u_dut (
        .clk    (clk),
        .resetN (resetN),
        .arb_if (if1)
    );

    // Zero cooldown and oversized speeds exercise the direct return and saturation
    foosball_kick_arbiter #(
        .COOLDOWN_FRAMES (0),
        .KICK_X_SPEED    (2000),
        .KICK_Y_SPEED    (5000)
    ) u_dut_nocool (
        .clk    (clk),
        .resetN (resetN),
        .arb_if (if2)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   nf;
    logic last_load;
    logic last_load2;
    logic [3:0] exp_g [4];
    int         exp_x [4];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_pulse();
        if1.startOfFrame = 1'b1;
        if2.startOfFrame = 1'b1;
        tick();
        if1.startOfFrame = 1'b0;
        if2.startOfFrame = 1'b0;
        last_load  = if1.loadSpeed;
        last_load2 = if2.loadSpeed;
    endtask

    task automatic frame();
        sof_pulse();
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic wait_grant(output int nframes);
        nframes = 0;
        do begin
            frame();
            nframes++;
        end while (!last_load && nframes < 40);
    endtask

    initial begin
        resetN = 1'b0;
        if1.startOfFrame = 1'b0; if1.kickReq = '0; if1.reqYUp = '0;
        if2.startOfFrame = 1'b0; if2.kickReq = '0; if2.reqYUp = '0;
        last_load = 1'b0; last_load2 = 1'b0;
        repeat (3) tick();
        check("rst_grant",  if1.grant,      0);
        check("rst_load",   if1.loadSpeed,  0);
        check("rst_x",      if1.kickXSpeed, 0);
        check("rst_y",      if1.kickYSpeed, 0);
        check("rst_active", if1.kickActive, 0);
        check("rst_busy",   if1.busy,       0);
        resetN = 1'b1;
        tick();

        // T1: single bot request, ball above centre
        if1.kickReq = 4'b0010; if1.reqYUp = 4'b0010;
        sof_pulse();
        check("t1_grant",  if1.grant,      4'b0010);
        check("t1_load",   if1.loadSpeed,  1);
        check("t1_x",      if1.kickXSpeed, -300);
        check("t1_y",      if1.kickYSpeed, -120);
        check("t1_active", if1.kickActive, 1);
        check("t1_busy",   if1.busy,       1);
        if1.kickReq = '0;
        tick();
        check("t1_load_1clk", if1.loadSpeed, 0);
        frames(7);
        check("t1_active_f7", if1.kickActive, 1);
        check("t1_grant_f7",  if1.grant,      4'b0010);
        frame();
        check("t1_active_f8", if1.kickActive, 0);
        check("t1_busy_f8",   if1.busy,       1);
        check("t1_grant_f8",  if1.grant,      0);
        check("t1_x_f8",      if1.kickXSpeed, 0);
        frames(14);
        check("t1_busy_f22",  if1.busy,       1);
        frame();
        check("t1_busy_f23",  if1.busy,       0);

        // T3: requests during KICK and COOLDOWN are dropped
        if1.kickReq = 4'b0001; if1.reqYUp = 4'b0000;
        wait_grant(nf);
        check("t3_nframes", nf,             1);
        check("t3_grant",   if1.grant,      4'b0001);
        check("t3_x",       if1.kickXSpeed, 300);
        check("t3_y",       if1.kickYSpeed, 120);
        if1.kickReq = '0;
        frames(2);
        if1.kickReq = 4'b0100;
        frame();
        check("t3_kick_noload",  last_load, 0);
        check("t3_kick_grant",   if1.grant, 4'b0001);
        if1.kickReq = '0;
        frames(5);
        check("t3_in_cool",      if1.kickActive, 0);
        frames(4);
        if1.kickReq = 4'b0100;
        frame();
        check("t3_cool_noload",  last_load, 0);
        check("t3_cool_grant",   if1.grant, 0);
        check("t3_cool_busy",    if1.busy,  1);
        if1.kickReq = '0;
        frames(10);
        check("t3_idle",         if1.busy,  0);

        // T4: reset in frame 4 of a kick
        if1.kickReq = 4'b0100;
        wait_grant(nf);
        check("t4_grant", if1.grant, 4'b0100);
        if1.kickReq = '0;
        frames(3);
        sof_pulse();
        tick();
        resetN = 1'b0;
        #1;
        check("t4_rst_grant",  if1.grant,      0);
        check("t4_rst_load",   if1.loadSpeed,  0);
        check("t4_rst_x",      if1.kickXSpeed, 0);
        check("t4_rst_y",      if1.kickYSpeed, 0);
        check("t4_rst_active", if1.kickActive, 0);
        check("t4_rst_busy",   if1.busy,       0);
        tick();
        resetN = 1'b1;
        if1.kickReq = 4'b1010;
        wait_grant(nf);
        check("t4_nframes", nf,        1);
        check("t4_regrant", if1.grant, 4'b0010);
        if1.kickReq = '0;
        frames(23);
        check("t4_idle", if1.busy, 0);

        // T2: round-robin with all rods requesting
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        if1.kickReq = 4'b1111; if1.reqYUp = 4'b1000;
        wait_grant(nf);
        check("t2_first_nf", nf,             1);
        check("t2_first_g",  if1.grant,      4'b0001);
        check("t2_first_y",  if1.kickYSpeed, 120);
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        exp_x[0] = -300;    exp_x[1] = 300;     exp_x[2] = -300;    exp_x[3] = 300;
        for (int i = 0; i < 4; i++) begin
            wait_grant(nf);
            check($sformatf("t2_nf%0d", i), nf,             24);
            check($sformatf("t2_g%0d",  i), if1.grant,      exp_g[i]);
            check($sformatf("t2_x%0d",  i), if1.kickXSpeed, exp_x[i]);
            if (i == 2) check("t2_y_rod3", if1.kickYSpeed, -120);
        end
        if1.kickReq = '0; if1.reqYUp = '0;
        frames(23);
        check("t2_idle", if1.busy, 0);

        // T5: rods 0 (human) and 1 (bot) with rrPtr at 1
        if1.kickReq = 4'b0011;
        wait_grant(nf);
        check("t5_nframes", nf, 1);
`ifdef KICK_PRIORITY_HUMAN_EN
        check("t5_grant", if1.grant,      4'b0001);
        check("t5_x",     if1.kickXSpeed, 300);
`else
        check("t5_grant", if1.grant,      4'b0010);
        check("t5_x",     if1.kickXSpeed, -300);
`endif
        if1.kickReq = '0;

        // T6: no cooldown, saturated speeds, held request
        if2.kickReq = 4'b0001; if2.reqYUp = 4'b0000;
        frame();
        check("t6_load",   last_load2,     1);
        check("t6_grant",  if2.grant,      4'b0001);
        check("t6_x_sat",  if2.kickXSpeed, 1023);
        check("t6_y_sat",  if2.kickYSpeed, 1023);
        if2.reqYUp = 4'b0001;
        frames(7);
        check("t6_active_f7", if2.kickActive, 1);
        frame();
        check("t6_idle_f8",   if2.busy,       0);
        check("t6_grant_f8",  if2.grant,      0);
        frame();
        check("t6_reload",    last_load2,     1);
        check("t6_regrant",   if2.grant,      4'b0001);
        check("t6_y_neg_sat", if2.kickYSpeed, -1023);
        if2.kickReq = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
